// File: rtl/apb_mem_slave_p.sv
// APB4 memory-mapped slave with configurable geometry, wait states, byte-lane merge,
// PSLVERR on malformed or out-of-range accesses and a saturating error counter.
module apb_mem_slave_p #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int SEL_WIDTH   = 4,
  parameter int SEL_IDX     = 0,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic                    pwrite,
  input  logic [SEL_WIDTH-1:0]    psel,
  input  logic                    penable,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr,
  output logic [7:0]              err_cnt
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [3:0]          WAIT_INIT = 4'(WAIT_STATES);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  logic [0:0]            state;
  logic [3:0]            wait_cnt;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic             sel;
  logic             setup;
  logic             access_ok;
  logic             complete;
  logic             bad;
  logic             mem_we;
  logic [IDX_W-1:0] idx;

  assign sel       = psel[SEL_IDX];
  assign idx       = paddr[IDX_W-1:0];
  assign setup     = (state == ST_IDLE) && sel && !penable;
  assign access_ok = (state == ST_ACCESS) && sel && penable;
  assign complete  = access_ok && (wait_cnt == 4'd0);

  // Out-of-range words, strobes on a read, and writes that touch no lane are all rejected.
  assign bad = ({1'b0, paddr} >= DEPTH_LIM)
             || (!pwrite && (pstrb != '0))
             || ( pwrite && (pstrb == '0));

  assign mem_we  = complete && pwrite && !err_q && !rst;
  assign pready  = complete;
  assign pslverr = err_q && complete;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      err_q    <= 1'b0;
      prdata   <= '0;
      err_cnt  <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (setup) begin
            state    <= ST_ACCESS;
            wait_cnt <= WAIT_INIT;
            err_q    <= bad;
            prdata   <= (!pwrite && !bad) ? mem[idx] : '0;
          end else begin
            prdata <= '0;
          end
        end
        ST_ACCESS: begin
          if (!access_ok) begin
            state  <= ST_IDLE;
            prdata <= '0;
          end else if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            state  <= ST_IDLE;
            prdata <= '0;
            if (err_q && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          prdata <= '0;
        end
      endcase
    end
  end

  // NOTE: the storage array has no reset branch; clearing it would force flops instead of RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (pstrb[i]) mem[idx][8*i +: 8] <= pwdata[8*i +: 8];
      end
    end
  end

endmodule
